// File: rtl/corelet_seq_ctrl.sv
// Purpose : run sequencer for the corelet (L0 -> MAC -> OFIFO -> SFU). From one start pulse it
//           drives inst[3:0], xmem reads and psum pointers for KIJ_NUM kernel offsets.
// Latency : xmem read -> l0_wr one cycle later; first l0_wr -> l0_rd/execute one cycle later.
// Backpressure: o_ready_l0=0 withholds the xmem read (cen=1, address held). l0_rd pauses while L0 is empty.
// Ports:
//   clk, reset (async active-low), start (one-cycle, IDLE only), o_ready_l0, wr_mem (SFU result strobe)
//   inst {l0_rd,l0_wr,execute,load}, xmem_cen (active-low), xmem_addr
//   pmem_raddr, pmem_waddr, pmem_wen, kij, busy, done (pulse), err (sticky psum overflow)
module corelet_seq_ctrl #(
  parameter int ROW     = 8,
  parameter int COL     = 8,
  parameter int NUM_ACT = 36,
  parameter int NUM_OUT = 16,
  parameter int KIJ_NUM = 9,
  parameter int WBASE   = 64,
  parameter int XAW     = 11,
  parameter int PAW     = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic           o_ready_l0,
  input  logic           wr_mem,
  output logic [3:0]     inst,
  output logic           xmem_cen,
  output logic [XAW-1:0] xmem_addr,
  output logic [PAW-1:0] pmem_raddr,
  output logic [PAW-1:0] pmem_waddr,
  output logic           pmem_wen,
  output logic [3:0]     kij,
  output logic           busy,
  output logic           done,
  output logic           err
);

  localparam int CW = $clog2(NUM_ACT + COL + ROW + 2);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WFILL  = 3'd1;
  localparam logic [2:0] S_WLOAD  = 3'd2;
  localparam logic [2:0] S_STREAM = 3'd3;
  localparam logic [2:0] S_DRAIN  = 3'd4;
  localparam logic [2:0] S_FIN    = 3'd5;

  logic [2:0]     state_q, state_d;
  logic [3:0]     kij_q, kij_d;
  logic [CW-1:0]  rd_cnt_q, rd_cnt_d;    // xmem reads issued in this phase
  logic [CW-1:0]  ph_cnt_q, ph_cnt_d;    // load cycles (W_LOAD) or l0_rd cycles (A_STREAM)
  logic [CW-1:0]  lvl_q, lvl_d;          // activation vectors sitting in L0
  logic [CW-1:0]  out_cnt_q, out_cnt_d;  // wr_mem pulses this kij
  logic [PAW-1:0] raddr_q, raddr_d;
  logic           err_q, err_d;
  logic           wr_pend_q;             // read accepted last cycle -> L0 write now

  logic           rd_issue;
  logic           l0_rd;
  logic           ld;
  logic           exe;
  logic           busy_c;
  logic [XAW-1:0] addr;

  always_comb begin
    state_d   = state_q;
    kij_d     = kij_q;
    rd_cnt_d  = rd_cnt_q;
    ph_cnt_d  = ph_cnt_q;
    lvl_d     = lvl_q;
    out_cnt_d = out_cnt_q;
    raddr_d   = raddr_q;
    err_d     = err_q;
    rd_issue  = 1'b0;
    l0_rd     = 1'b0;
    ld        = 1'b0;
    exe       = 1'b0;
    addr      = '0;
    busy_c    = (state_q != S_IDLE) && (state_q != S_FIN);

    // Psum write tracking runs in every busy state. The read pointer runs one
    // address ahead of the write pointer so psum data is ready for the next write.
    if (busy_c && wr_mem) begin
      out_cnt_d = out_cnt_q + CW'(1);
      raddr_d   = PAW'(out_cnt_q + CW'(2));
      if (out_cnt_q >= CW'(NUM_OUT)) err_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_WFILL;
          kij_d     = '0;
          err_d     = 1'b0;
          rd_cnt_d  = '0;
          ph_cnt_d  = '0;
          lvl_d     = '0;
          out_cnt_d = '0;
          raddr_d   = '0;
        end
      end
      S_WFILL: begin
        addr = XAW'(WBASE) + XAW'(kij_q) * XAW'(COL) + XAW'(rd_cnt_q);
        if (rd_cnt_q < CW'(COL)) begin
          rd_issue = o_ready_l0;
          if (o_ready_l0) rd_cnt_d = rd_cnt_q + CW'(1);
        end else begin
          // The last weight write (if any) lands this cycle, so load never overlaps l0_wr.
          state_d  = S_WLOAD;
          ph_cnt_d = '0;
        end
      end
      S_WLOAD: begin
        ld       = 1'b1;
        l0_rd    = (ph_cnt_q < CW'(COL));
        ph_cnt_d = ph_cnt_q + CW'(1);
        if (ph_cnt_q == CW'(COL + ROW - 1)) begin
          state_d  = S_STREAM;
          ph_cnt_d = '0;
          rd_cnt_d = '0;
          lvl_d    = '0;
        end
      end
      S_STREAM: begin
        addr = XAW'(rd_cnt_q);
        if (rd_cnt_q < CW'(NUM_ACT)) begin
          rd_issue = o_ready_l0;
          if (o_ready_l0) rd_cnt_d = rd_cnt_q + CW'(1);
        end
        // Only read vectors already written in an earlier cycle.
        l0_rd = (ph_cnt_q < CW'(NUM_ACT)) && (lvl_q != '0);
        exe   = l0_rd;
        if (l0_rd) ph_cnt_d = ph_cnt_q + CW'(1);
        lvl_d = lvl_q + CW'(wr_pend_q) - CW'(l0_rd);
        if (ph_cnt_q == CW'(NUM_ACT)) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (out_cnt_q >= CW'(NUM_OUT)) begin
          if (kij_q < 4'(KIJ_NUM - 1)) begin
            kij_d    = kij_q + 4'd1;
            state_d  = S_WFILL;
            rd_cnt_d = '0;
          end else begin
            state_d = S_FIN;
          end
          // Pointer restart wins over a pulse landing in this same cycle.
          out_cnt_d = '0;
          raddr_d   = '0;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      kij_q     <= '0;
      rd_cnt_q  <= '0;
      ph_cnt_q  <= '0;
      lvl_q     <= '0;
      out_cnt_q <= '0;
      raddr_q   <= '0;
      err_q     <= 1'b0;
      wr_pend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      kij_q     <= kij_d;
      rd_cnt_q  <= rd_cnt_d;
      ph_cnt_q  <= ph_cnt_d;
      lvl_q     <= lvl_d;
      out_cnt_q <= out_cnt_d;
      raddr_q   <= raddr_d;
      err_q     <= err_d;
      wr_pend_q <= rd_issue;
    end
  end

  assign inst       = {l0_rd, wr_pend_q, exe, ld};
  assign xmem_cen   = ~rd_issue;
  assign xmem_addr  = addr;
  assign pmem_waddr = out_cnt_q[PAW-1:0];
  assign pmem_raddr = raddr_q;
  assign pmem_wen   = wr_mem & busy_c;
  assign kij        = kij_q;
  assign busy       = busy_c;
  assign done       = (state_q == S_FIN);
  assign err        = err_q;

endmodule

// File: tb/tb_corelet_seq_ctrl.sv
// Purpose : directed bench for corelet_seq_ctrl with read-address and psum-address scoreboards.
// Latency : expectations are queued when a run starts and popped as the DUT issues reads/writes.
// Backpressure: o_ready_l0 is dropped for three cycles mid-stream in one run.
module tb_corelet_seq_ctrl;

  localparam int ROW = 8, COL = 8, NUM_ACT = 36, NUM_OUT = 16, KIJ_NUM = 9;
  localparam int WBASE = 64, XAW = 11, PAW = 4;

  logic           clk = 1'b0;
  logic           reset, start, o_ready_l0, wr_mem;
  logic [3:0]     inst;
  logic           xmem_cen;
  logic [XAW-1:0] xmem_addr;
  logic [PAW-1:0] pmem_raddr, pmem_waddr;
  logic           pmem_wen;
  logic [3:0]     kij;
  logic           busy, done, err;

  corelet_seq_ctrl #(
    .ROW(ROW), .COL(COL), .NUM_ACT(NUM_ACT), .NUM_OUT(NUM_OUT), .KIJ_NUM(KIJ_NUM),
    .WBASE(WBASE), .XAW(XAW), .PAW(PAW)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .o_ready_l0(o_ready_l0), .wr_mem(wr_mem),
    .inst(inst), .xmem_cen(xmem_cen), .xmem_addr(xmem_addr),
    .pmem_raddr(pmem_raddr), .pmem_waddr(pmem_waddr), .pmem_wen(pmem_wen),
    .kij(kij), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [31:0] xq[$];   // expected xmem read addresses, in order
  logic [31:0] wq[$];   // expected pmem write addresses, in order

  int wr_tot, rd_tot, wen_cnt, done_cnt, exec_cnt, exec_tot, kij_m, pulse_n, pend, bad_kij;
  logic        prev_cen_low, ra_chk;
  logic [31:0] ra_exp;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push_run(input int bad);
    for (int k = 0; k < KIJ_NUM; k++) begin
      for (int i = 0; i < COL; i++) xq.push_back(32'(WBASE + k * COL + i));
      for (int a = 0; a < NUM_ACT; a++) xq.push_back(32'(a));
      for (int p = 0; p < NUM_OUT; p++) wq.push_back(32'(p));
      if (k == bad) wq.push_back(32'(NUM_OUT % (1 << PAW)));
    end
  endtask

  task automatic clear_counts();
    wr_tot = 0; rd_tot = 0; wen_cnt = 0; done_cnt = 0; exec_cnt = 0; exec_tot = 0;
    kij_m = 0; pulse_n = 0; pend = 0; prev_cen_low = 1'b0; ra_chk = 1'b0; ra_exp = 0;
  endtask

  task automatic run_begin(input int bad);
    clear_counts();
    bad_kij = bad;
    @(posedge clk); #1;
    start = 1'b1;
    push_run(bad);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 4000 && done_cnt == 0; i++) @(posedge clk);
    repeat (5) @(posedge clk);
    #1;
  endtask

  // Monitor and SFU model, sampled on the falling edge.
  initial forever begin
    @(negedge clk);
    if (!reset) begin
      xq.delete();
      wq.delete();
      clear_counts();
    end else begin
      logic [31:0] e;
      chk("l0_wr_after_read", {31'b0, inst[2]}, {31'b0, prev_cen_low});
      prev_cen_low = !xmem_cen;
      if (!xmem_cen) begin
        e = (xq.size() > 0) ? xq.pop_front() : 32'hFFFF_FFFF;
        chk("xmem_addr", {21'b0, xmem_addr}, e);
      end
      if (inst[2]) wr_tot++;
      if (inst[3]) rd_tot++;
      chk("l0_rd_le_wr", {31'b0, rd_tot <= wr_tot}, 1);
      chk("exec_and_load", {31'b0, inst[1] & inst[0]}, 0);
      chk("wr_and_load", {31'b0, inst[2] & inst[0]}, 0);
      if (ra_chk) chk("pmem_raddr", {28'b0, pmem_raddr}, ra_exp);
      ra_chk = 1'b0;
      if (pmem_wen) begin
        wen_cnt++;
        pulse_n++;
        e = (wq.size() > 0) ? wq.pop_front() : 32'hFFFF_FFFF;
        chk("pmem_waddr", {28'b0, pmem_waddr}, e);
        ra_chk = (pulse_n <= NUM_OUT);
        ra_exp = (e + 2) % (1 << PAW);
      end
      if (done) begin
        done_cnt++;
        chk("busy_at_done", {31'b0, busy}, 0);
      end
      if (inst[1]) begin
        exec_cnt++;
        exec_tot++;
        if (exec_cnt == NUM_ACT) begin
          pend += (kij_m == bad_kij) ? NUM_OUT + 1 : NUM_OUT;
          exec_cnt = 0;
          pulse_n = 0;
          kij_m++;
        end
      end
    end
  end

  // SFU result strobes, one per cycle while any are owed.
  initial forever begin
    @(posedge clk);
    #1;
    if (reset === 1'b1 && pend > 0) begin
      wr_mem = 1'b1;
      pend--;
    end else begin
      wr_mem = 1'b0;
    end
  end

  initial begin
    bad_kij = -1;
    clear_counts();
    reset = 1'b0; start = 1'b0; o_ready_l0 = 1'b1; wr_mem = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("rst_inst", {28'b0, inst}, 0);
    chk("rst_cen", {31'b0, xmem_cen}, 1);
    chk("rst_xaddr", {21'b0, xmem_addr}, 0);
    chk("rst_raddr", {28'b0, pmem_raddr}, 0);
    chk("rst_waddr", {28'b0, pmem_waddr}, 0);
    chk("rst_kij", {28'b0, kij}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_done", {31'b0, done}, 0);
    chk("rst_err", {31'b0, err}, 0);

    // Reset in the middle of weight fill.
    run_begin(-1);
    repeat (4) @(posedge clk);
    #1;
    chk("fill_busy", {31'b0, busy}, 1);
    chk("fill_cen", {31'b0, xmem_cen}, 0);
    #1 reset = 1'b0;
    #1;
    chk("abort_inst", {28'b0, inst}, 0);
    chk("abort_cen", {31'b0, xmem_cen}, 1);
    chk("abort_busy", {31'b0, busy}, 0);
    chk("abort_kij", {28'b0, kij}, 0);
    @(posedge clk);
    #1 reset = 1'b1;

    // Full run; a second start mid-run must be ignored.
    run_begin(-1);
    repeat (30) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk("ign_start_busy", {31'b0, busy}, 1);
    chk("ign_start_kij", {28'b0, kij}, 0);
    wait_done();
    chk("r1_done_pulses", done_cnt, 1);
    chk("r1_busy_end", {31'b0, busy}, 0);
    chk("r1_l0_wr_total", wr_tot, KIJ_NUM * (COL + NUM_ACT));
    chk("r1_l0_rd_total", rd_tot, KIJ_NUM * (COL + NUM_ACT));
    chk("r1_exec_total", exec_tot, KIJ_NUM * NUM_ACT);
    chk("r1_wen_total", wen_cnt, KIJ_NUM * NUM_OUT);
    chk("r1_xq_left", xq.size(), 0);
    chk("r1_wq_left", wq.size(), 0);
    chk("r1_kij_end", {28'b0, kij}, KIJ_NUM - 1);
    chk("r1_err", {31'b0, err}, 0);

    // Stall mid-stream in kij 0, overflowing psum count in kij 2.
    run_begin(2);
    for (int i = 0; i < 1000 && exec_tot < 10; i++) @(posedge clk);
    #1 o_ready_l0 = 1'b0;
    for (int s = 0; s < 3; s++) begin
      #1;
      chk("stall_cen", {31'b0, xmem_cen}, 1);
      chk("stall_addr", {21'b0, xmem_addr}, (xq.size() > 0) ? xq[0] : 32'hFFFF_FFFF);
      @(posedge clk);
    end
    #1 o_ready_l0 = 1'b1;
    wait_done();
    chk("r2_done_pulses", done_cnt, 1);
    chk("r2_err_sticky", {31'b0, err}, 1);
    chk("r2_l0_wr_total", wr_tot, KIJ_NUM * (COL + NUM_ACT));
    chk("r2_l0_rd_total", rd_tot, KIJ_NUM * (COL + NUM_ACT));
    chk("r2_wen_total", wen_cnt, KIJ_NUM * NUM_OUT + 1);
    chk("r2_xq_left", xq.size(), 0);
    chk("r2_wq_left", wq.size(), 0);
    repeat (10) @(posedge clk);
    #1;
    chk("r2_err_held", {31'b0, err}, 1);

    // Next start clears err; run completes cleanly.
    run_begin(-1);
    chk("r3_err_cleared", {31'b0, err}, 0);
    chk("r3_busy", {31'b0, busy}, 1);
    wait_done();
    chk("r3_done_pulses", done_cnt, 1);
    chk("r3_err", {31'b0, err}, 0);
    chk("r3_wq_left", wq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
